// File: rtl/game_pkg.sv
// game_pkg: shared encodings for the player controller slice.
// Direction codes, control_state field layout and the frame FSM states.
package game_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // control_state is {pressed[4:0], released[4:0]}; both halves share the
  // same per-button offsets.
  localparam int PRESS_LSB  = 5;
  localparam int REL_LSB    = 0;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_ATTACK = 4;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    UPDATE
  } ctrl_state_e;

  // Resolve several requested directions to one: up > down > left > right.
  // Callers only use the result when at least one bit is set.
  function automatic logic [1:0] pick_dir(input logic [3:0] dirs);
    if (dirs[BTN_UP])        return DIR_UP;
    else if (dirs[BTN_DOWN]) return DIR_DOWN;
    else if (dirs[BTN_LEFT]) return DIR_LEFT;
    else                     return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/player_controller_if.sv
// player_controller_if: frame handshake between the input collector
// (master) and the player controller (slave).
interface player_controller_if;

  logic       frame_end;
  logic [9:0] control_state;
  logic       state_ack;

  modport master (
    output frame_end,
    output control_state,
    input  state_ack
  );

  modport slave (
    input  frame_end,
    input  control_state,
    output state_ack
  );

endinterface

// File: rtl/action_timer.sv
// action_timer: attack/cooldown counter pair advanced once per frame tick.
// active is high while the attack counter runs; ready says a start offered
// on this tick will be taken.
module action_timer #(
  parameter int ATTACK_FRAMES   = 3,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tick,
  output logic active,
  output logic ready
);

  localparam int AW = $clog2(ATTACK_FRAMES + 2);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 2);

  logic [AW-1:0] atk_cnt;
  logic [CW-1:0] cool_cnt;

  // The tick that takes the cooldown from 1 to 0 already counts as idle,
  // so a press in that frame starts a new attack instead of being dropped.
  assign ready = (atk_cnt == '0) && (cool_cnt <= CW'(1));

  // Per tick: start a new attack, or run the attack down, then the cooldown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      atk_cnt  <= '0;
      cool_cnt <= '0;
      active   <= 1'b0;
    end else if (tick) begin
      if (start && ready) begin
        atk_cnt  <= AW'(ATTACK_FRAMES);
        cool_cnt <= '0;
        active   <= 1'b1;
      end else if (atk_cnt != '0) begin
        atk_cnt <= atk_cnt - 1'b1;
        if (atk_cnt == AW'(1)) begin
          active   <= 1'b0;
          cool_cnt <= CW'(COOLDOWN_FRAMES);
        end
      end else if (cool_cnt != '0) begin
        cool_cnt <= cool_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_controller.sv
// player_controller: turns the per-frame sticky button word into grid
// position, facing direction and a timed attack flag.
// Optional feature: HOLD_REPEAT_EN (held-direction auto-repeat).
module player_controller
  import game_pkg::*;
#(
  parameter int GRID_W          = 16,
  parameter int GRID_H          = 12,
  parameter int START_X         = 0,
  parameter int START_Y         = 0,
  parameter int ATTACK_FRAMES   = 3,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  player_controller_if.slave        ctrl,
  output logic [$clog2(GRID_W)-1:0] player_x,
  output logic [$clog2(GRID_H)-1:0] player_y,
  output logic [1:0]                player_dir,
  output logic                      player_attack
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  ctrl_state_e   state;
  ctrl_state_e   state_next;
  logic          update_now;
  logic [9:0]    snap;
  logic [3:0]    press_dirs;
  logic          attack_press;
  logic [3:0]    move_dirs;
  logic          move_req;
  logic [1:0]    move_dir;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;
  logic [1:0]    dir_next;
  logic          timer_ready;
  logic          timer_start;
  logic          snap_unused;

  assign press_dirs   = snap[PRESS_LSB +: 4];
  assign attack_press = snap[PRESS_LSB + BTN_ATTACK];
  assign move_dir     = pick_dir(move_dirs);
  assign timer_start  = attack_press && timer_ready;

  // Frame sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state; the frame's results are committed on the edge leaving SAMPLE
  // so they are visible while UPDATE is current, two cycles after frame_end.
  always_comb begin
    state_next = state;
    update_now = 1'b0;
    case (state)
      IDLE:    if (ctrl.frame_end) state_next = SAMPLE;
      SAMPLE:  begin
        state_next = UPDATE;
        update_now = 1'b1;
      end
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot taken on entry to SAMPLE; state_ack is high for that one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap           <= '0;
      ctrl.state_ack <= 1'b0;
    end else begin
      ctrl.state_ack <= (state == IDLE) && ctrl.frame_end;
      if ((state == IDLE) && ctrl.frame_end) snap <= ctrl.control_state;
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);

  logic [3:0]    rel_dirs;
  logic [3:0]    held;
  logic [3:0]    held_next;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_next;

  assign rel_dirs    = snap[REL_LSB +: 4];
  assign snap_unused = snap[REL_LSB + BTN_ATTACK];

  // A fresh press moves at once and restarts the repeat period; otherwise a
  // still-held direction moves every REPEAT_FRAMES frames. Release beats press.
  always_comb begin
    held_next = (held | press_dirs) & ~rel_dirs;
    rep_next  = '0;
    move_dirs = press_dirs;
    move_req  = 1'b0;
    if (|press_dirs) begin
      move_req = 1'b1;
    end else if (|held_next) begin
      if (rep_cnt == RW'(REPEAT_FRAMES - 1)) begin
        move_dirs = held_next;
        move_req  = 1'b1;
      end else begin
        rep_next = rep_cnt + 1'b1;
      end
    end
  end

  // Held-direction and repeat-period registers, advanced once per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held    <= '0;
      rep_cnt <= '0;
    end else if (update_now) begin
      held    <= held_next;
      rep_cnt <= rep_next;
    end
  end
`else
  localparam int repeat_unused = REPEAT_FRAMES;

  assign snap_unused = ^snap[REL_LSB +: 5];

  // Only a press in this frame's snapshot produces a move.
  always_comb begin
    move_dirs = press_dirs;
    move_req  = |press_dirs;
  end
`endif

  // Facing always follows the chosen direction; the step itself is blocked by
  // walls and by an attack that is already running at the start of the frame.
  always_comb begin
    x_next   = player_x;
    y_next   = player_y;
    dir_next = player_dir;
    if (move_req) begin
      dir_next = move_dir;
      if (!player_attack) begin
        case (move_dir)
          DIR_UP:    if (player_y != '0)    y_next = player_y - 1'b1;
          DIR_DOWN:  if (player_y != Y_MAX) y_next = player_y + 1'b1;
          DIR_LEFT:  if (player_x != '0)    x_next = player_x - 1'b1;
          DIR_RIGHT: if (player_x != X_MAX) x_next = player_x + 1'b1;
          default:   ;
        endcase
      end
    end
  end

  // Position and facing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      player_x   <= XW'(START_X);
      player_y   <= YW'(START_Y);
      player_dir <= DIR_UP;
    end else if (update_now) begin
      player_x   <= x_next;
      player_y   <= y_next;
      player_dir <= dir_next;
    end
  end

  action_timer #(
    .ATTACK_FRAMES   (ATTACK_FRAMES),
    .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
  ) u_action_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (timer_start),
    .tick   (update_now),
    .active (player_attack),
    .ready  (timer_ready)
  );

endmodule

// File: tb/tb_player_controller.sv
// tb_player_controller: directed and randomized frames against a frame-level
// reference model of position, facing and attack timing.
module tb_player_controller;

  localparam int GRID_W  = 16;
  localparam int GRID_H  = 12;
  localparam int START_X = 0;
  localparam int START_Y = 0;
  localparam int ATK     = 3;
  localparam int COOL    = 4;
  localparam int REP     = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] player_x;
  logic [3:0] player_y;
  logic [1:0] player_dir;
  logic       player_attack;

  player_controller_if bus ();

  player_controller #(
    .GRID_W          (GRID_W),
    .GRID_H          (GRID_H),
    .START_X         (START_X),
    .START_Y         (START_Y),
    .ATTACK_FRAMES   (ATK),
    .COOLDOWN_FRAMES (COOL),
    .REPEAT_FRAMES   (REP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ctrl          (bus),
    .player_x      (player_x),
    .player_y      (player_y),
    .player_dir    (player_dir),
    .player_attack (player_attack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  int exp_x;
  int exp_y;
  int exp_dir;
  bit exp_att;
  bit exp_ack;

  int       m_frame;
  int       m_start;
  bit [3:0] m_held;
  int       m_rep;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic model_reset();
    exp_x   = START_X;
    exp_y   = START_Y;
    exp_dir = 0;
    exp_att = 1'b0;
    exp_ack = 1'b0;
    m_frame = 0;
    m_start = -1000;
    m_held  = '0;
    m_rep   = 0;
  endtask

  // Frame-level model: an attack started in frame s is visible after frames
  // s..s+ATK-1 and the next one may start at frame s+ATK+COOL.
  task automatic model_frame(input logic [9:0] cs);
    bit [3:0] dirs;
    bit       go;
    bit       pre_att;
    m_frame++;
    pre_att = (m_frame - 1 >= m_start) && (m_frame - 1 < m_start + ATK);
    if (cs[9] && (m_frame >= m_start + ATK + COOL)) m_start = m_frame;
    exp_att = (m_frame >= m_start) && (m_frame < m_start + ATK);
    dirs = cs[8:5];
    go   = (cs[8:5] != 4'b0);
`ifdef HOLD_REPEAT_EN
    m_held = (m_held | cs[8:5]) & ~cs[3:0];
    if (cs[8:5] != 4'b0) m_rep = 0;
    else if (m_held != 4'b0) begin
      m_rep++;
      if (m_rep == REP) begin
        dirs  = m_held;
        go    = 1'b1;
        m_rep = 0;
      end
    end else m_rep = 0;
`endif
    if (go) begin
      if (dirs[0]) begin
        exp_dir = 0;
        if (!pre_att && exp_y > 0) exp_y = exp_y - 1;
      end else if (dirs[1]) begin
        exp_dir = 1;
        if (!pre_att && exp_y < GRID_H - 1) exp_y = exp_y + 1;
      end else if (dirs[2]) begin
        exp_dir = 2;
        if (!pre_att && exp_x > 0) exp_x = exp_x - 1;
      end else begin
        exp_dir = 3;
        if (!pre_att && exp_x < GRID_W - 1) exp_x = exp_x + 1;
      end
    end
  endtask

  // One frame as the collector would run it; entered and left just after a
  // rising edge with the controller in IDLE.
  task automatic apply_stimulus(input logic [9:0] cs, input bit extra_fe);
    bus.control_state = cs;
    bus.frame_end     = 1'b1;
    @(posedge clk); #1;
    bus.frame_end = extra_fe;
    exp_ack       = 1'b1;
    @(posedge clk); #1;
    bus.frame_end     = 1'b0;
    bus.control_state = '0;
    exp_ack           = 1'b0;
    model_frame(cs);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("state_ack", int'(bus.state_ack), int'(exp_ack));
      check_output("player_x", int'(player_x), exp_x);
      check_output("player_y", int'(player_y), exp_y);
      check_output("player_dir", int'(player_dir), exp_dir);
      check_output("player_attack", int'(player_attack), int'(exp_att));
    end
  end

  initial begin
    logic [9:0] rnd_cs;
    int         gap;

    reset             = 1'b0;
    bus.frame_end     = 1'b0;
    bus.control_state = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_x", int'(player_x), START_X);
    check_output("rst_y", int'(player_y), START_Y);
    check_output("rst_dir", int'(player_dir), 0);
    check_output("rst_attack", int'(player_attack), 0);
    check_output("rst_ack", int'(bus.state_ack), 0);
    reset  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(10'b00001_00000, 1'b0);
    check_output("up_wall_y", int'(player_y), 0);
    check_output("up_wall_x", int'(player_x), 0);
    check_output("up_wall_dir", int'(player_dir), 0);

    repeat (20) apply_stimulus(10'b01000_00000, 1'b0);
    check_output("right_wall_x", int'(player_x), 15);
    check_output("right_wall_dir", int'(player_dir), 3);
    repeat (13) apply_stimulus(10'b00010_00000, 1'b0);
    check_output("bottom_wall_y", int'(player_y), 11);
    check_output("bottom_wall_dir", int'(player_dir), 1);
    repeat (10) apply_stimulus(10'b00100_00000, 1'b0);
    repeat (6) apply_stimulus(10'b00001_00000, 1'b0);
    check_output("at55_x", int'(player_x), 5);
    check_output("at55_y", int'(player_y), 5);

    apply_stimulus(10'b01001_00000, 1'b0);
    check_output("prio_x", int'(player_x), 5);
    check_output("prio_y", int'(player_y), 4);
    check_output("prio_dir", int'(player_dir), 0);

    apply_stimulus(10'b10000_00000, 1'b0);
    check_output("atk_n", int'(player_attack), 1);
    apply_stimulus(10'b00000_00000, 1'b0);
    check_output("atk_n1", int'(player_attack), 1);
    apply_stimulus(10'b00000_00000, 1'b0);
    check_output("atk_n2", int'(player_attack), 1);
    apply_stimulus(10'b00000_00000, 1'b0);
    check_output("atk_n3", int'(player_attack), 0);
    apply_stimulus(10'b10000_00000, 1'b0);
    check_output("atk_n4_ignored", int'(player_attack), 0);
    apply_stimulus(10'b00000_00000, 1'b0);
    apply_stimulus(10'b00000_00000, 1'b0);
    apply_stimulus(10'b10000_00000, 1'b0);
    check_output("atk_n7_taken", int'(player_attack), 1);
    repeat (3) apply_stimulus(10'b00100_00000, 1'b0);
    check_output("atk_left_x", int'(player_x), 5);
    check_output("atk_left_dir", int'(player_dir), 2);
    apply_stimulus(10'b00100_00000, 1'b0);
    check_output("after_atk_left_x", int'(player_x), 4);

    bus.control_state = 10'b00010_00000;
    bus.frame_end     = 1'b1;
    @(posedge clk); #1;
    bus.frame_end = 1'b0;
    exp_ack       = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_output("midrst_x", int'(player_x), START_X);
    check_output("midrst_y", int'(player_y), START_Y);
    check_output("midrst_ack", int'(bus.state_ack), 0);
    @(posedge clk); #1;
    bus.control_state = '0;
    reset             = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("midrst_nomove_y", int'(player_y), START_Y);

    for (int i = 0; i < 150; i++) begin
      rnd_cs = 10'($urandom);
      apply_stimulus(rnd_cs, ($urandom_range(0, 7) == 0));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

`ifdef HOLD_REPEAT_EN
    repeat (16) apply_stimulus(10'b00100_00100, 1'b0);
    check_output("hold_home_x", int'(player_x), 0);
    apply_stimulus(10'b01000_00000, 1'b0);
    check_output("hold_press_x", int'(player_x), 1);
    repeat (3) apply_stimulus(10'b00000_00000, 1'b0);
    check_output("hold_f3_x", int'(player_x), 1);
    apply_stimulus(10'b00000_00000, 1'b0);
    check_output("hold_f4_x", int'(player_x), 2);
    repeat (4) apply_stimulus(10'b00000_00000, 1'b0);
    check_output("hold_f8_x", int'(player_x), 3);
    apply_stimulus(10'b00000_01000, 1'b0);
    repeat (4) apply_stimulus(10'b00000_00000, 1'b0);
    check_output("hold_released_x", int'(player_x), 3);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
